cdb_wb_arbiter: RTL

//  Shares the single ROB result-write port (value/ready/jumppc by ROB tag) among NREQ

---
 rtl/cdb_wb_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cdb_wb_arbiter.sv
// rtl/cdb_wb_arbiter.sv - per-producer result FIFOs, round-robin pick into a registered ROB writeback stage
module cdb_wb_arbiter #(
  parameter int NREQ   = 2,
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32,
  parameter int QDEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           flush,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ*ROB_W-1:0]          req_tag,
  input  logic [NREQ*DATA_W-1:0]         req_value,
  input  logic [NREQ*DATA_W-1:0]         req_jumppc,
  input  logic [NREQ-1:0]                req_jvalid,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output logic [ROB_W-1:0]               wb_tag,
  output logic [DATA_W-1:0]              wb_value,
  output logic [DATA_W-1:0]              wb_jumppc,
  output logic                           wb_jvalid,
  output logic [$clog2(NREQ)-1:0]        wb_src
);

  localparam int SRC_W = $clog2(NREQ);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROB_W + 2 * DATA_W + 1;

  logic [ENT_W-1:0] mem    [NREQ][QDEPTH];
  logic [PTR_W-1:0] wr_ptr [NREQ];
  logic [PTR_W-1:0] rd_ptr [NREQ];
  logic [CNT_W-1:0] count  [NREQ];

  logic [NREQ-1:0]  push;
  logic [NREQ-1:0]  pop;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] rr_next;
  logic             grant_found;
  logic             out_free;
  logic             arb_en;
  logic [SRC_W:0]   scan;

  logic [ENT_W-1:0]  head;
  logic [ROB_W-1:0]  head_tag;
  logic [DATA_W-1:0] head_value;
  logic [DATA_W-1:0] head_jumppc;
  logic              head_jvalid;

  assign out_free = ~wb_valid | wb_ready;
  assign arb_en   = rdy & out_free & ~flush;

  // Ready looks only at the registered count, so it never depends on req_valid.
  always_comb begin
    req_ready = '0;
    push      = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rdy & (count[i] != CNT_W'(QDEPTH));
      push[i]      = req_valid[i] & req_ready[i] & ~flush;
    end
  end

  // Walk the producers starting at rr_ptr, wrapping mod NREQ; first non-empty wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    pop         = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
      if (scan >= (SRC_W + 1)'(NREQ)) begin
        scan = scan - (SRC_W + 1)'(NREQ);
      end
      if (!grant_found && count[scan[SRC_W-1:0]] != '0) begin
        grant_found = 1'b1;
        grant_idx   = scan[SRC_W-1:0];
      end
    end
    if (arb_en && grant_found) begin
      pop[grant_idx] = 1'b1;
    end
  end

  assign rr_next = (grant_idx == SRC_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  assign head = mem[grant_idx][rd_ptr[grant_idx]];
  assign {head_tag, head_value, head_jumppc, head_jvalid} = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < NREQ; i++) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          count[i]  <= '0;
        end
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (push[i]) begin
            mem[i][wr_ptr[i]] <= {req_tag[i*ROB_W +: ROB_W], req_value[i*DATA_W +: DATA_W],
                                  req_jumppc[i*DATA_W +: DATA_W], req_jvalid[i]};
            wr_ptr[i] <= wr_ptr[i] + 1'b1;
          end
          if (pop[i]) begin
            rd_ptr[i] <= rd_ptr[i] + 1'b1;
          end
          case ({push[i], pop[i]})
            2'b10:   count[i] <= count[i] + 1'b1;
            2'b01:   count[i] <= count[i] - 1'b1;
            default: count[i] <= count[i];
          endcase
        end
      end
    end
  end

  // Flush only drops wb_valid; rr_ptr survives so fairness carries across epochs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      wb_valid  <= 1'b0;
      wb_tag    <= '0;
      wb_value  <= '0;
      wb_jumppc <= '0;
      wb_jvalid <= 1'b0;
      wb_src    <= '0;
    end else if (rdy) begin
      if (flush) begin
        wb_valid <= 1'b0;
      end else if (out_free) begin
        if (grant_found) begin
          wb_valid  <= 1'b1;
          wb_tag    <= head_tag;
          wb_value  <= head_value;
          wb_jumppc <= head_jumppc;
          wb_jvalid <= head_jvalid;
          wb_src    <= grant_idx;
          rr_ptr    <= rr_next;
        end else if (wb_ready) begin
          wb_valid <= 1'b0;
        end
      end
    end
  end

endmodule
